// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: four byte reads per 32-bit big-endian instruction, valid/ready
// hand-off to decode, branch redirect and sticky halt detection. Optional counters: FETCH_PERF_EN.
module fetch_sequencer #(
    parameter int            N         = 32,
    parameter int            M         = 10,
    parameter logic [M+1:0]  RESET_PC  = '0,
    parameter logic [N-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic           clk,
    input  logic           rst,
    output logic           mem_rd,
    output logic [M+1:0]   mem_addr,
    input  logic [7:0]     mem_data,
    output logic [N-1:0]   instr,
    output logic [M+1:0]   instr_pc,
    output logic           instr_valid,
    input  logic           instr_ready,
    input  logic           redirect,
    input  logic [M+1:0]   redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]    fetch_count,
    output logic [31:0]    stall_count,
`endif
    output logic           is_halted
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_VALID  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]   r_state;
    logic [1:0]   r_k;
    logic [M+1:0] r_pc;
    logic [23:0]  r_shift;
    logic [N-1:0] r_instr;
    logic [M+1:0] r_instr_pc;

    logic [N-1:0] w_word;
    logic [M+1:0] w_target;
    logic         w_redir;
    logic         w_xfer;

    assign w_word   = {r_shift, mem_data};
    assign w_target = redirect_pc & ~((M+2)'(3));
    assign w_redir  = redirect && (r_state != S_HALTED);
    assign w_xfer   = (r_state == S_VALID) && instr_ready;

    // Outputs are forced low while rst is held so nothing escapes during reset.
    assign mem_rd      = !rst && (r_state == S_FETCH);
    assign mem_addr    = {r_pc[M+1:2], r_k};
    assign instr_valid = !rst && (r_state == S_VALID);
    assign is_halted   = !rst && (r_state == S_HALTED);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_k        <= 2'd0;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (w_redir) begin
            r_state <= S_FETCH;
            r_k     <= 2'd0;
            r_pc    <= w_target;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_k <= r_k + 2'd1;
                    if (r_k == 2'd3)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_word == HALT_WORD) begin
                        r_state <= S_HALTED;
                    end else begin
                        r_state    <= S_VALID;
                        r_instr    <= w_word;
                        r_instr_pc <= r_pc;
                    end
                end
                S_VALID: begin
                    if (instr_ready) begin
                        r_state <= S_FETCH;
                        r_k     <= 2'd0;
                        r_pc    <= r_pc + (M+2)'(4);
                    end
                end
                default: r_state <= S_HALTED;
            endcase
        end
    end

    // Byte k arrives the cycle after its read: FETCH k=1..3 capture bytes 0..2, DRAIN sees byte 3.
    always_ff @(posedge clk) begin
        if (((r_state == S_FETCH) && (r_k != 2'd0)) || (r_state == S_DRAIN))
            r_shift <= {r_shift[15:0], mem_data};
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_xfer)
                r_fetch_count <= r_fetch_count + 32'd1;
            if ((r_state == S_VALID) && !instr_ready)
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized ready/redirect traffic, checked
// by a phase-level reference model. Define FETCH_PERF_EN to also cover the performance counters.
module tb_fetch_sequencer;
    localparam int          M    = 10;
    localparam int          AW   = M + 2;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          is_halted;
`ifdef FETCH_PERF_EN
    logic [31:0]   fetch_count;
    logic [31:0]   stall_count;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(.N(32), .M(M), .RESET_PC('0), .HALT_WORD(HALT)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_EN
        .fetch_count(fetch_count), .stall_count(stall_count),
`endif
        .is_halted(is_halted)
    );

    // Byte-wide memory: data for a read appears in the following cycle.
    logic [7:0]    mem [0:4095];
    logic          rd_q;
    logic [AW-1:0] addr_q;
    always @(posedge clk) begin
        rd_q   <= mem_rd;
        addr_q <= mem_addr;
    end
    assign mem_data = rd_q ? mem[addr_q] : 8'hA5;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        return {mem[a], mem[a + AW'(1)], mem[a + AW'(2)], mem[a + AW'(3)]};
    endfunction

    // Reference model: phase 0 = fetching (cnt = cycles since fetch start), 1 = valid, 2 = halted.
    int            m_phase, m_cnt, m_fetch, m_stall;
    logic [AW-1:0] m_pc;
    bit            m_live   = 1'b0;
    bit            rst_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_mem_rd", mem_rd, 0);
            check("rst_valid", instr_valid, 0);
            check("rst_halted", is_halted, 0);
            if (rst_prev) begin
                check("rst_instr", instr, 0);
                check("rst_instr_pc", instr_pc, 0);
            end
            m_live = 1'b1; m_pc = '0; m_phase = 0; m_cnt = 0; m_fetch = 0; m_stall = 0;
        end else if (m_live) begin
            case (m_phase)
                0: begin
                    check("mdl_fetch_valid", instr_valid, 0);
                    check("mdl_fetch_halted", is_halted, 0);
                    if (m_cnt < 4) begin
                        check("mdl_rd", mem_rd, 1);
                        check("mdl_addr", mem_addr, m_pc + AW'(m_cnt));
                    end else begin
                        check("mdl_drain_rd", mem_rd, 0);
                    end
                end
                1: begin
                    check("mdl_valid", instr_valid, 1);
                    check("mdl_valid_rd", mem_rd, 0);
                    check("mdl_instr", instr, word_at(m_pc));
                    check("mdl_instr_pc", instr_pc, m_pc);
                end
                default: begin
                    check("mdl_halted", is_halted, 1);
                    check("mdl_halt_valid", instr_valid, 0);
                    check("mdl_halt_rd", mem_rd, 0);
                end
            endcase
            if (m_phase == 1) begin
                if (instr_ready) m_fetch++;
                else m_stall++;
            end
            if (m_phase != 2) begin
                if (redirect) begin
                    m_pc = redirect_pc & ~AW'(3);
                    m_phase = 0; m_cnt = 0;
                end else if (m_phase == 0) begin
                    m_cnt++;
                    if (m_cnt == 5) m_phase = (word_at(m_pc) == HALT) ? 2 : 1;
                end else if (instr_ready) begin
                    m_pc = m_pc + AW'(4);
                    m_phase = 0; m_cnt = 0;
                end
            end
        end
        rst_prev = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (!instr_valid && n < bound) begin
            tick();
            n++;
        end
        if (!instr_valid) check("timeout_valid", 0, 1);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom_range(0, 254));
    endtask

    int n;

    initial begin
        rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        fill_mem();
        {mem[0], mem[1], mem[2], mem[3]}             = 32'h1234_5678;
        {mem[256], mem[257], mem[258], mem[259]}     = 32'hABCD_EF01;
        {mem[4092], mem[4093], mem[4094], mem[4095]} = 32'h9ABC_DEF0;

        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("t1_first_rd", mem_rd, 1);
        check("t1_first_addr", mem_addr, 0);

        instr_ready = 1'b1;
        wait_valid(20, n);
        check("t2_latency", n, 5);
        check("t2_instr", instr, 32'h1234_5678);
        check("t2_instr_pc", instr_pc, 0);
        tick();
        check("t2_next_addr", mem_addr, 12'h004);

        instr_ready = 1'b0;
        wait_valid(20, n);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_valid", instr_valid, 1);
            check("t3_hold_pc", instr_pc, 12'h004);
            check("t3_hold_rd", mem_rd, 0);
        end
        instr_ready = 1'b1;
        tick();
        check("t3_after_accept", mem_addr, 12'h008);

        tick();
        tick();
        redirect = 1'b1; redirect_pc = 12'h101;
        tick();
        redirect = 1'b0;
        check("t4_redir_addr", mem_addr, 12'h100);
        wait_valid(20, n);
        check("t4_latency", n, 5);
        check("t4_instr", instr, 32'hABCD_EF01);
        check("t4_instr_pc", instr_pc, 12'h100);

        redirect = 1'b1; redirect_pc = 12'hFFC;
        tick();
        redirect = 1'b0;
        check("t5_redir_accept_addr", mem_addr, 12'hFFC);
        wait_valid(20, n);
        check("t5_instr_pc", instr_pc, 12'hFFC);
        tick();
        check("t5_wrap_addr", mem_addr, 12'h000);

        rst = 1'b1;
        {mem[8], mem[9], mem[10], mem[11]} = HALT;
        tick();
        tick();
        rst = 1'b0; instr_ready = 1'b1;
        n = 0;
        while (!is_halted && n < 40) begin
            tick();
            n++;
        end
        check("t6_halt_cycle", n, 17);
        redirect = 1'b1; redirect_pc = 12'h000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_stay_halted", is_halted, 1);
            check("t6_no_valid", instr_valid, 0);
            check("t6_no_rd", mem_rd, 0);
        end
        redirect = 1'b0; rst = 1'b1;
        #1;
        check("t6_rst_clears", is_halted, 0);
        tick();
        rst = 1'b0;
        #1;
        check("t6_restart_addr", mem_addr, 0);
        check("t6_restart_rd", mem_rd, 1);
        {mem[8], mem[9], mem[10], mem[11]} = 32'h0102_0304;

`ifdef FETCH_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0; instr_ready = 1'b1;
        wait_valid(20, n);
        tick();
        instr_ready = 1'b0;
        wait_valid(20, n);
        tick();
        tick();
        instr_ready = 1'b1;
        tick();
        wait_valid(20, n);
        tick();
        instr_ready = 1'b0;
        check("t7_fetch_count", fetch_count, 3);
        check("t7_stall_count", stall_count, 2);
`endif

        rst = 1'b1;
        fill_mem();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = AW'($urandom);
            tick();
        end
        redirect = 1'b0;
        @(negedge clk);
`ifdef FETCH_PERF_EN
        check("rand_fetch_count", fetch_count, 32'(m_fetch));
        check("rand_stall_count", stall_count, 32'(m_stall));
`endif
        check("rand_not_halted", is_halted, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
